maze_pixel_gen: RTL
===================

Name: maze_pixel_gen

Overview:
Pixel generator that sits directly downstream of vga_sync. It consumes pixel_x/pixel_y/video_on/p_tick and produces the 8-bit RGB (3-3-2) stream for the display. It renders a 40x30 tile maze from an external synchronous-read tile RAM, overlays the player tile, and moves the player on request using a wall-checked handshake serviced during vertical blank. hsync/vsync are delayed to match the render pipeline.

Parameters:
TILE_BITS, 4, log2 of tile edge in pixels (16x16 tiles)
MAP_W, 40, tiles per row
MAP_H, 30, tile rows
START_X, 1, player column after reset
START_Y, 1, player row after reset
WALL_RGB, 8'b000_000_11, wall colour
PATH_RGB, 8'b111_111_11, path colour
GOAL_RGB, 8'b000_111_00, goal colour
PLAYER_RGB, 8'b111_000_00, player colour

Ports:
clk  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-low reset
p_tick  input  1  pixel enable from vga_sync (1 clk in 2)
video_on  input  1  visible-area flag from vga_sync
pixel_x  input  10  current column from vga_sync
pixel_y  input  10  current row from vga_sync
hsync_in  input  1  hsync from vga_sync
vsync_in  input  1  vsync from vga_sync
map_addr  output  11  tile RAM address, row*MAP_W+col
map_data  input  2  tile RAM read data, 1 clk after map_addr; 00 path, 01 wall, 10 goal, 11 treated as wall
move_valid  input  1  move request
move_dir  input  2  00 up, 01 down, 10 left, 11 right
move_ready  output  1  FSM can accept a move
move_done  output  1  1-clk pulse when a request completes
move_ok  output  1  valid with move_done: 1 = player moved
goal_reached  output  1  1-clk pulse when player enters a goal tile
player_x  output  6  player column
player_y  output  5  player row
hsync_out  output  1  hsync_in delayed 2 p_ticks
vsync_out  output  1  vsync_in delayed 2 p_ticks
rgb  output  8  pixel colour

Behaviour:
- Reset (reset==0 at posedge): rgb, map_addr, hsync_out, vsync_out, pipeline regs = 0; player_x=START_X, player_y=START_Y; FSM=IDLE; move_done/move_ok/goal_reached=0. A move in progress is abandoned without effect.
- Render pipeline advances only on p_tick. S0: map_addr <= (pixel_y>>TILE_BITS)*MAP_W + (pixel_x>>TILE_BITS) (multiply by shifts: row<<5 + row<<3). Latch video_on, player-hit flag (tile col/row == player_x/player_y), hsync_in, vsync_in. S1 (next p_tick): rgb <= 0 if delayed video_on==0; else PLAYER_RGB if player-hit; else colour by map_data. Latency 2 p_ticks (4 clk), identical for rgb and hsync_out/vsync_out.
- The FSM owns map_addr only in READ. A request is only started during vertical blank, when rgb is forced to 0, so rendering is never disturbed.
- FSM states:
  - IDLE: move_ready=1. On move_valid&&move_ready, latch the dir, compute the target tile, go to WAIT_VB.
  - WAIT_VB: on p_tick with pixel_y>=480, the FSM checks bounds. If the target is outside 0..MAP_W-1 / 0..MAP_H-1 (including 6-bit/5-bit wrap below 0), it pulses move_done with move_ok=0 and returns to IDLE with no RAM read. Otherwise it drives map_addr=target and goes to READ.
  - READ: one clk, so data is valid next clk. Go to CHECK.
  - CHECK: if map_data is 01 or 11, pulse move_done with move_ok=0. Else update player_x/player_y, pulse move_done with move_ok=1, and pulse goal_reached in the same clk if map_data==10. Return to IDLE.
- move_ready=0 in all states except IDLE. move_valid while busy is ignored, not queued. The player position updates only in vblank, so there is no mid-frame tearing.

Test Plan:
- Reset: hold reset=0 for 3 clk -> rgb=0, player=(1,1), move_ready=1, hsync_out=vsync_out=0.
- Render latency: all-path map, video_on=1, pixel (32,16) on tile (2,1) -> map_addr=42; rgb=8'hFF exactly 2 p_ticks later. Tile (1,1) -> 8'hE0 (player). video_on=0 -> rgb=0.
- Legal move: tile (2,1)=path, move_dir=11 in the visible area -> FSM waits until pixel_y=480, map_addr=42 in READ, then move_done=1, move_ok=1, player_x=2.
- Blocked: tile (1,0) is a wall, dir=00 -> move_done=1, move_ok=0, player unchanged. Player at (0,y), dir=10 -> rejected with no READ cycle.
- Goal: tile (3,1)=10, player at (2,1), dir=11 -> goal_reached and move_done pulse in the same clk, player_x=3.
- Reset mid-move: reset=0 during READ -> player returns to (1,1), no move_done pulse, FSM=IDLE.

Source files
------------

// File: rtl/maze_pixel_gen.sv
// Maze pixel generator: renders a 40x30 tile map from an external synchronous
// tile RAM, overlays the player, and services wall-checked moves during vblank.
module maze_pixel_gen #(
  parameter int         TILE_BITS  = 4,
  parameter int         MAP_W      = 40,
  parameter int         MAP_H      = 30,
  parameter int         START_X    = 1,
  parameter int         START_Y    = 1,
  parameter logic [7:0] WALL_RGB   = 8'b000_000_11,
  parameter logic [7:0] PATH_RGB   = 8'b111_111_11,
  parameter logic [7:0] GOAL_RGB   = 8'b000_111_00,
  parameter logic [7:0] PLAYER_RGB = 8'b111_000_00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [10:0] map_addr,
  input  logic [1:0]  map_data,
  input  logic        move_valid,
  input  logic [1:0]  move_dir,
  output logic        move_ready,
  output logic        move_done,
  output logic        move_ok,
  output logic        goal_reached,
  output logic [5:0]  player_x,
  output logic [4:0]  player_y,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic [7:0]  rgb
);

  localparam logic [9:0] V_VISIBLE = 10'd480;

  // Move handshake: a request is accepted on a clock edge where move_valid and
  // move_ready are both high; each accepted request yields exactly one
  // move_done pulse (with move_ok) unless reset abandons it first.
  typedef enum logic [1:0] {IDLE, WAIT_VB, READ, CHECK} state_t;
  state_t state, state_next;

  logic [5:0]  tgt_x;
  logic [4:0]  tgt_y;
  logic        vid_d, hit_d, hs_d, vs_d;
  logic [5:0]  pix_col, pix_row;
  logic [10:0] pix_addr, tgt_addr;
  logic        player_hit, tgt_oob, vb_go;

  // row*40 as (row<<5)+(row<<3); the map is fixed at 40 tiles wide.
  function automatic logic [10:0] tile_addr(input logic [5:0] col, input logic [5:0] row);
    logic [10:0] r;
    r = {5'd0, row};
    return (r << 5) + (r << 3) + {5'd0, col};
  endfunction

  assign pix_col    = 6'(pixel_x >> TILE_BITS);
  assign pix_row    = 6'(pixel_y >> TILE_BITS);
  assign pix_addr   = tile_addr(pix_col, pix_row);
  assign tgt_addr   = tile_addr(tgt_x, {1'b0, tgt_y});
  assign player_hit = (pix_col == player_x) && (pix_row == {1'b0, player_y});
  // Moving below 0 wraps to 63/31, which this range check also rejects.
  assign tgt_oob    = (tgt_x >= 6'(MAP_W)) || (tgt_y >= 5'(MAP_H));
  assign vb_go      = (state == WAIT_VB) && p_tick && (pixel_y >= V_VISIBLE);
  assign move_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (move_valid) state_next = WAIT_VB;
      WAIT_VB: if (vb_go) state_next = tgt_oob ? IDLE : READ;
      READ:    state_next = CHECK;
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      map_addr     <= '0;
      rgb          <= '0;
      hsync_out    <= 1'b0;
      vsync_out    <= 1'b0;
      vid_d        <= 1'b0;
      hit_d        <= 1'b0;
      hs_d         <= 1'b0;
      vs_d         <= 1'b0;
      tgt_x        <= '0;
      tgt_y        <= '0;
      player_x     <= 6'(START_X);
      player_y     <= 5'(START_Y);
      move_done    <= 1'b0;
      move_ok      <= 1'b0;
      goal_reached <= 1'b0;
    end else begin
      move_done    <= 1'b0;
      move_ok      <= 1'b0;
      goal_reached <= 1'b0;

      if (state == IDLE && move_valid) begin
        tgt_x <= player_x;
        tgt_y <= player_y;
        case (move_dir)
          2'b00:   tgt_y <= player_y - 5'd1;
          2'b01:   tgt_y <= player_y + 5'd1;
          2'b10:   tgt_x <= player_x - 6'd1;
          default: tgt_x <= player_x + 6'd1;
        endcase
      end

      // The FSM borrows map_addr for one lookup; rgb is blanked in vblank anyway.
      if (vb_go && !tgt_oob)
        map_addr <= tgt_addr;
      else if (p_tick && state != READ)
        map_addr <= pix_addr;

      if (p_tick) begin
        vid_d     <= video_on;
        hit_d     <= player_hit;
        hs_d      <= hsync_in;
        vs_d      <= vsync_in;
        hsync_out <= hs_d;
        vsync_out <= vs_d;
        if (!vid_d)     rgb <= 8'h00;
        else if (hit_d) rgb <= PLAYER_RGB;
        else begin
          case (map_data)
            2'b00:   rgb <= PATH_RGB;
            2'b10:   rgb <= GOAL_RGB;
            default: rgb <= WALL_RGB;
          endcase
        end
      end

      if (vb_go && tgt_oob) move_done <= 1'b1;

      if (state == CHECK) begin
        move_done <= 1'b1;
        // Bit 0 set means wall (01) or the reserved code 11.
        if (!map_data[0]) begin
          move_ok      <= 1'b1;
          player_x     <= tgt_x;
          player_y     <= tgt_y;
          goal_reached <= map_data[1];
        end
      end
    end
  end

endmodule
